// File: rtl/key_scanner_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM encoding, key map, row/col patterns.
package key_scanner_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_SCAN     = 2'd0;
    localparam state_t ST_DEBOUNCE = 2'd1;
    localparam state_t ST_HELD     = 2'd2;
    localparam state_t ST_RELEASE  = 2'd3;

    localparam logic [3:0] ROW_IDLE = 4'b1110;
    localparam logic [3:0] COL_NONE = 4'b1111;

    localparam int unsigned TYPEMATIC_FIRST  = 32;
    localparam int unsigned TYPEMATIC_REPEAT = 8;

    // Entry {row_idx, col_idx}; row0 = 1 2 3 A ... row3 = E 0 F D
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    function automatic logic [3:0] key_lookup(input logic [1:0] row_idx, input logic [1:0] col_idx);
        return KEY_MAP[{row_idx, col_idx}];
    endfunction

    // True only when exactly one column line is pulled low
    function automatic logic single_low(input logic [3:0] col);
        logic [3:0] n;
        n = ~col;
        return (n != 4'd0) && ((n & (n - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] col);
        casez (col)
            4'b???0: return 2'd0;
            4'b??01: return 2'd1;
            4'b?011: return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic [3:0] row_drive(input logic [1:0] row_idx);
        return ~(4'b0001 << row_idx);
    endfunction

endpackage

// File: rtl/key_scanner_tick.sv
// Free-running divider producing a one-cycle scan tick every SCAN_DIV clocks.
// Latency: tick combinational from counter; no backpressure.
// Backpressure: none, runs unconditionally.
module scan_tick_gen #(
    parameter int SCAN_DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(SCAN_DIV - 1);

    logic [15:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 16'd0;
        end else if (cnt == LAST) begin
            cnt <= 16'd0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/key_scanner.sv
// 4x4 keypad scanner with per-tick debounce, one-deep key holding register and sticky overrun.
// Latency: key_valid rises on the tick edge that completes press debounce (plus 2-clk col sync).
// Backpressure: key_valid holds until key_ack; a new key arriving un-acked is dropped (overrun).
// Optional KEY_SCANNER_TYPEMATIC_EN: auto-repeat the held key after 32 ticks, then every 8.
module key_scanner
    import key_scanner_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       key_held,
    output logic       overrun
);

    localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_CNT);

    logic [3:0] col_meta;
    logic [3:0] col_sync;
    logic       tick;

    state_t     state,    state_d;
    logic [1:0] row_idx,  row_idx_d;
    logic [3:0] col_q,    col_q_d;
    logic [3:0] stab_cnt, stab_cnt_d;
    logic       held_d;
    logic       emit;
    logic [3:0] emit_code;

`ifdef KEY_SCANNER_TYPEMATIC_EN
    logic [5:0] rep_cnt,   rep_cnt_d;
    logic       rep_first, rep_first_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_meta <= COL_NONE;
            col_sync <= COL_NONE;
        end else begin
            col_meta <= col;
            col_sync <= col_meta;
        end
    end

    scan_tick_gen #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    always_comb begin
        state_d    = state;
        row_idx_d  = row_idx;
        col_q_d    = col_q;
        stab_cnt_d = stab_cnt;
        held_d     = key_held;
        emit       = 1'b0;
        emit_code  = key_lookup(row_idx, low_index(col_q));
`ifdef KEY_SCANNER_TYPEMATIC_EN
        rep_cnt_d   = rep_cnt;
        rep_first_d = rep_first;
`endif
        if (tick) begin
            case (state)
                ST_SCAN: begin
                    // Ghosted multi-key patterns are treated like no key
                    if (single_low(col_sync)) begin
                        col_q_d    = col_sync;
                        stab_cnt_d = 4'd1;
                        if (DB_LAST == 4'd1) begin
                            emit      = 1'b1;
                            emit_code = key_lookup(row_idx, low_index(col_sync));
                            held_d    = 1'b1;
                            state_d   = ST_HELD;
`ifdef KEY_SCANNER_TYPEMATIC_EN
                            rep_cnt_d   = 6'd0;
                            rep_first_d = 1'b1;
`endif
                        end else begin
                            state_d = ST_DEBOUNCE;
                        end
                    end else begin
                        row_idx_d = row_idx + 2'd1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (col_sync == col_q) begin
                        stab_cnt_d = stab_cnt + 4'd1;
                        if (stab_cnt_d == DB_LAST) begin
                            emit    = 1'b1;
                            held_d  = 1'b1;
                            state_d = ST_HELD;
`ifdef KEY_SCANNER_TYPEMATIC_EN
                            rep_cnt_d   = 6'd0;
                            rep_first_d = 1'b1;
`endif
                        end
                    end else begin
                        state_d   = ST_SCAN;
                        row_idx_d = row_idx + 2'd1;
                    end
                end
                ST_HELD: begin
                    if (col_sync == COL_NONE) begin
                        stab_cnt_d = 4'd1;
                        if (DB_LAST == 4'd1) begin
                            held_d    = 1'b0;
                            state_d   = ST_SCAN;
                            row_idx_d = 2'd0;
                        end else begin
                            state_d = ST_RELEASE;
                        end
                    end
`ifdef KEY_SCANNER_TYPEMATIC_EN
                    else begin
                        rep_cnt_d = rep_cnt + 6'd1;
                        if (rep_cnt_d == (rep_first ? 6'(TYPEMATIC_FIRST) : 6'(TYPEMATIC_REPEAT))) begin
                            emit        = 1'b1;
                            rep_cnt_d   = 6'd0;
                            rep_first_d = 1'b0;
                        end
                    end
`endif
                end
                default: begin
                    if (col_sync == COL_NONE) begin
                        stab_cnt_d = stab_cnt + 4'd1;
                        if (stab_cnt_d == DB_LAST) begin
                            held_d    = 1'b0;
                            state_d   = ST_SCAN;
                            row_idx_d = 2'd0;
                        end
                    end else begin
                        state_d = ST_HELD;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_SCAN;
            row_idx  <= 2'd0;
            col_q    <= COL_NONE;
            stab_cnt <= 4'd0;
            key_held <= 1'b0;
        end else begin
            state    <= state_d;
            row_idx  <= row_idx_d;
            col_q    <= col_q_d;
            stab_cnt <= stab_cnt_d;
            key_held <= held_d;
        end
    end

`ifdef KEY_SCANNER_TYPEMATIC_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt   <= 6'd0;
            rep_first <= 1'b1;
        end else begin
            rep_cnt   <= rep_cnt_d;
            rep_first <= rep_first_d;
        end
    end
`endif

    // An ack on the emit edge frees the slot, so the new key replaces the old one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (emit) begin
            if (!key_valid || key_ack) begin
                key_code  <= emit_code;
                key_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (key_valid && key_ack) begin
            key_valid <= 1'b0;
        end
    end

    assign row = row_drive(row_idx);

endmodule

// File: tb/tb_key_scanner.sv
// Self-checking bench for key_scanner: keypad matrix model, scripted and random presses,
// scoreboard of acknowledged keys against a key-map reference.
module tb_key_scanner;

    localparam int SD = 4;
    localparam int DB = 2;

    localparam logic [3:0] REF_MAP [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                                            4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
    localparam logic [3:0] ROWS [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic        overrun;
    wire         key_ack;
    logic        manual_ack = 1'b0;
    logic        auto_ack = 1'b0;
    int          ack_mode = 0;
    logic [15:0] key_mask = 16'd0;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [3:0]  consumed [$];
    int          cons_cyc [$];

    key_scanner #(
        .SCAN_DIV     (SD),
        .DEBOUNCE_CNT (DB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .col       (col),
        .row       (row),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ack   (key_ack),
        .key_held  (key_held),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Physical keypad: a pressed switch shorts its column to its row when that row is driven low
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!row[r] && key_mask[r*4+c]) col[c] = 1'b0;
    end

    assign key_ack = (ack_mode == 0) ? manual_ack : auto_ack;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial forever begin
        @(posedge clk);
        #1;
        auto_ack = (ack_mode == 2) ? 1'b1 : ($urandom_range(0, 2) == 0);
    end

    initial forever begin
        @(negedge clk);
        if (rst_n && key_valid && key_ack) begin
            consumed.push_back(key_code);
            cons_cyc.push_back(cyc);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic at_neg;
        @(negedge clk);
        #1;
    endtask

    task automatic wait_tick;
        at_neg();
        while (cyc % SD != 0) at_neg();
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) wait_tick();
    endtask

    task automatic wait_valid(input logic want, input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (key_valid === want) begin
                ok = 1'b1;
                break;
            end
            at_neg();
        end
    endtask

    task automatic find_row(input logic [3:0] want, output int t0, output bit ok);
        ok = 1'b0;
        t0 = 0;
        for (int i = 0; i < 12; i++) begin
            if (row === want) begin
                ok = 1'b1;
                t0 = cyc;
                break;
            end
            wait_tick();
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        at_neg();
        at_neg();
        n_cmp++; if (row !== 4'b1110) begin n_err++; $display("FAIL reset_row: got %b want 1110", row); end
        n_cmp++; if (key_code !== 4'h0) begin n_err++; $display("FAIL reset_code: got %h want 0", key_code); end
        n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", key_valid); end
        n_cmp++; if (key_held !== 1'b0) begin n_err++; $display("FAIL reset_held: got %b want 0", key_held); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        rst_n = 1'b1;
    endtask

    task automatic test_scan;
        logic [3:0] exp_row;
        for (int i = 0; i < 24; i++) begin
            at_neg();
            exp_row = ROWS[(cyc / SD) % 4];
            n_cmp++; if (row !== exp_row) begin n_err++; $display("FAIL scan_row: cyc %0d got %b want %b", cyc, row, exp_row); end
            n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL scan_valid: cyc %0d got %b want 0", cyc, key_valid); end
        end
    endtask

    task automatic test_press_ack;
        bit ok;
        ack_mode = 0;
        key_mask = 16'd1 << 9;
        wait_valid(1'b1, 200, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL press_timeout: key_valid %b want 1", key_valid); end
        n_cmp++; if (key_code !== 4'h8) begin n_err++; $display("FAIL press_code: got %h want 8", key_code); end
        n_cmp++; if (key_held !== 1'b1) begin n_err++; $display("FAIL press_held: got %b want 1", key_held); end
        at_neg();
        n_cmp++; if (key_valid !== 1'b1 || key_code !== 4'h8) begin n_err++; $display("FAIL press_hold_valid: got %b/%h want 1/8", key_valid, key_code); end
        manual_ack = 1'b1;
        at_neg();
        manual_ack = 1'b0;
        n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL press_ack_clear: got %b want 0", key_valid); end
        wait_ticks(8);
        n_cmp++; if (key_held !== 1'b1 || key_valid !== 1'b0) begin n_err++; $display("FAIL press_still_held: held/valid %b/%b want 1/0", key_held, key_valid); end
        key_mask = 16'd0;
        wait_tick();
        n_cmp++; if (key_held !== 1'b1) begin n_err++; $display("FAIL release_early: held %b want 1", key_held); end
        wait_tick();
        n_cmp++; if (key_held !== 1'b0) begin n_err++; $display("FAIL release_held: held %b want 0", key_held); end
        n_cmp++; if (row !== 4'b1110) begin n_err++; $display("FAIL release_row0: row %b want 1110", row); end
    endtask

    task automatic test_bounce;
        bit ok;
        consumed.delete();
        ack_mode = 1;
        for (int i = 0; i < 6; i++) begin
            key_mask = (i % 2 == 0) ? 16'd1 : 16'd0;
            wait_tick();
        end
        key_mask = 16'd1;
        wait_ticks(10);
        key_mask = 16'd0;
        wait_ticks(4);
        wait_valid(1'b0, 200, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL bounce_drain: key_valid %b want 0", key_valid); end
        n_cmp++; if (consumed.size() != 1) begin n_err++; $display("FAIL bounce_count: got %0d keys want 1", consumed.size()); end
        else if (consumed[0] !== 4'h1) begin n_err++; $display("FAIL bounce_code: got %h want 1", consumed[0]); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL bounce_overrun: got %b want 0", overrun); end
    endtask

    task automatic test_overrun;
        int  t0;
        bit  ok;
        ack_mode = 0;
        manual_ack = 1'b0;
        key_mask = 16'd1 << 5;
        wait_ticks(8);
        key_mask = 16'd0;
        wait_ticks(4);
        n_cmp++; if (key_valid !== 1'b1 || key_code !== 4'h5 || overrun !== 1'b0) begin n_err++; $display("FAIL ovr_first: v/code/ovr %b/%h/%b want 1/5/0", key_valid, key_code, overrun); end
        key_mask = 16'd1 << 10;
        wait_ticks(8);
        key_mask = 16'd0;
        wait_ticks(4);
        n_cmp++; if (key_code !== 4'h5) begin n_err++; $display("FAIL ovr_code_kept: got %h want 5", key_code); end
        n_cmp++; if (overrun !== 1'b1 || key_valid !== 1'b1) begin n_err++; $display("FAIL ovr_flag: ovr/valid %b/%b want 1/1", overrun, key_valid); end
        // '0' lives on row3: detected one tick after row3 is driven, emitted one tick later
        key_mask = 16'd1 << 13;
        find_row(4'b0111, t0, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL ovr_find_row3: row %b want 0111", row); end
        while (cyc < t0 + 2 * SD - 1) at_neg();
        manual_ack = 1'b1;
        at_neg();
        manual_ack = 1'b0;
        n_cmp++; if (key_code !== 4'h0 || key_valid !== 1'b1) begin n_err++; $display("FAIL ovr_ack_emit: code/valid %h/%b want 0/1", key_code, key_valid); end
        n_cmp++; if (overrun !== 1'b1 || key_held !== 1'b1) begin n_err++; $display("FAIL ovr_ack_flags: ovr/held %b/%b want 1/1", overrun, key_held); end
        manual_ack = 1'b1;
        at_neg();
        manual_ack = 1'b0;
        n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL ovr_final_ack: valid %b want 0", key_valid); end
        key_mask = 16'd0;
        wait_ticks(4);
    endtask

    task automatic test_multi_reset;
        bit  saw_row3;
        int  t0;
        bit  ok;
        ack_mode = 0;
        saw_row3 = 1'b0;
        key_mask = (16'd1 << 4) | (16'd1 << 6);
        for (int i = 0; i < 12; i++) begin
            wait_tick();
            if (row === 4'b0111) saw_row3 = 1'b1;
            n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL multi_valid: tick %0d valid %b want 0", i, key_valid); end
        end
        n_cmp++; if (saw_row3 !== 1'b1) begin n_err++; $display("FAIL multi_scan: row3 seen %b want 1", saw_row3); end
        key_mask = 16'd1 << 9;
        find_row(4'b1011, t0, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL rst_find_row2: row %b want 1011", row); end
        while (cyc < t0 + SD + 2) at_neg();
        n_cmp++; if (row !== 4'b1011 || key_valid !== 1'b0) begin n_err++; $display("FAIL rst_debounce: row/valid %b/%b want 1011/0", row, key_valid); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (row !== 4'b1110) begin n_err++; $display("FAIL rst_row: got %b want 1110", row); end
        n_cmp++; if (key_valid !== 1'b0 || key_code !== 4'h0) begin n_err++; $display("FAIL rst_key: valid/code %b/%h want 0/0", key_valid, key_code); end
        n_cmp++; if (key_held !== 1'b0 || overrun !== 1'b0) begin n_err++; $display("FAIL rst_flags: held/ovr %b/%b want 0/0", key_held, overrun); end
        key_mask = 16'd0;
        at_neg();
        rst_n = 1'b1;
        wait_tick();
        n_cmp++; if (row !== 4'b1101) begin n_err++; $display("FAIL rst_restart: row %b want 1101", row); end
        wait_ticks(10);
        n_cmp++; if (key_valid !== 1'b0 || key_held !== 1'b0) begin n_err++; $display("FAIL rst_discard: valid/held %b/%b want 0/0", key_valid, key_held); end
    endtask

    task automatic test_random;
        logic [3:0] expq [$];
        int         k;
        bit         ok;
        rst_n = 1'b0;
        key_mask = 16'd0;
        at_neg();
        rst_n = 1'b1;
        consumed.delete();
        ack_mode = 1;
        for (int i = 0; i < 10; i++) begin
            k = $urandom_range(0, 15);
            key_mask = 16'd1 << k;
            wait_ticks($urandom_range(8, 12));
            key_mask = 16'd0;
            wait_ticks(4);
            expq.push_back(REF_MAP[k]);
        end
        wait_valid(1'b0, 200, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL rand_drain: valid %b want 0", key_valid); end
        n_cmp++; if (consumed.size() != expq.size()) begin n_err++; $display("FAIL rand_count: got %0d want %0d", consumed.size(), expq.size()); end
        for (int i = 0; i < expq.size() && i < consumed.size(); i++) begin
            n_cmp++; if (consumed[i] !== expq[i]) begin n_err++; $display("FAIL rand_key[%0d]: got %h want %h", i, consumed[i], expq[i]); end
        end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL rand_overrun: got %b want 0", overrun); end
    endtask

    task automatic test_typematic;
        bit ok;
        consumed.delete();
        cons_cyc.delete();
        ack_mode = 2;
        key_mask = 16'd1 << 3;
        wait_valid(1'b1, 200, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL tm_first: valid %b want 1", key_valid); end
        wait_ticks(50);
        key_mask = 16'd0;
        wait_ticks(4);
        repeat (4) at_neg();
`ifdef KEY_SCANNER_TYPEMATIC_EN
        n_cmp++; if (consumed.size() != 4) begin n_err++; $display("FAIL tm_count: got %0d want 4", consumed.size()); end
        for (int i = 0; i < consumed.size(); i++) begin
            n_cmp++; if (consumed[i] !== 4'hA) begin n_err++; $display("FAIL tm_code[%0d]: got %h want a", i, consumed[i]); end
        end
        if (cons_cyc.size() == 4) begin
            n_cmp++; if (cons_cyc[1] - cons_cyc[0] != 32 * SD) begin n_err++; $display("FAIL tm_gap0: got %0d want %0d", cons_cyc[1] - cons_cyc[0], 32 * SD); end
            n_cmp++; if (cons_cyc[2] - cons_cyc[1] != 8 * SD) begin n_err++; $display("FAIL tm_gap1: got %0d want %0d", cons_cyc[2] - cons_cyc[1], 8 * SD); end
            n_cmp++; if (cons_cyc[3] - cons_cyc[2] != 8 * SD) begin n_err++; $display("FAIL tm_gap2: got %0d want %0d", cons_cyc[3] - cons_cyc[2], 8 * SD); end
        end
`else
        n_cmp++; if (consumed.size() != 1) begin n_err++; $display("FAIL single_emit_count: got %0d want 1 (entries at %0d)", consumed.size(), cons_cyc.size()); end
        else if (consumed[0] !== 4'hA) begin n_err++; $display("FAIL single_emit_code: got %h want a", consumed[0]); end
`endif
        n_cmp++; if (key_held !== 1'b0 || overrun !== 1'b0) begin n_err++; $display("FAIL tm_end: held/ovr %b/%b want 0/0", key_held, overrun); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_press_ack();
        test_bounce();
        test_overrun();
        test_multi_reset();
        test_random();
        test_typematic();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/key_scanner.md
KEY_SCANNER -- requirements
Module: key_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000: clk cycles per scan tick (row dwell), legal range 2..65535.
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 4: consecutive stable tick samples needed for press and for release, legal range 1..15.
REQ-003 SHALL have ports (clock and reset first):
 clk  in  1  single system clock, all state on rising edge.
 rst_n  in  1  asynchronous active-low reset.
 col  in  4  keypad column sense, active-low, pulled up externally, asynchronous to clk.
 row  out  4  keypad row drive, active-low, exactly one bit low at all times.
 key_code  out  4  hex value of accepted key.
 key_valid  out  1  key_code holds an unconsumed key.
 key_ack  in  1  consumer accepts key_code.
 key_held  out  1  debounced key currently pressed.
 overrun  out  1  sticky flag: a key was dropped.

Function
REQ-004 SHALL double-register col before any use; all col references below mean the synchronised value.
REQ-005 SHALL generate a one-cycle scan tick every SCAN_DIV clk cycles from a free-running counter.
REQ-006 SHALL implement FSM states SCAN, DEBOUNCE, HELD and RELEASE; row changes only on a tick while in SCAN.
REQ-007 In SCAN on each tick: if col==4'b1111, SHALL advance row 1110->1101->1011->0111->1110 (wrap); otherwise SHALL latch row index and col, freeze row, and enter DEBOUNCE with stable count 1.
REQ-008 SHALL treat col with more than one bit low as no key: state stays SCAN and row advances.
REQ-009 In DEBOUNCE on each tick: col equal to latched value SHALL increment the count; any other value SHALL return to SCAN and advance row.
REQ-010 When the count reaches DEBOUNCE_CNT, SHALL emit the key, set key_held and enter HELD; with DEBOUNCE_CNT=1 the key is emitted on the entry tick.
REQ-011 Key value SHALL be KEY_MAP[row_idx*4+col_idx]: row0 1,2,3,A; row1 4,5,6,B; row2 7,8,9,C; row3 E,0,F,D.
REQ-012 In HELD a tick with col==4'b1111 SHALL enter RELEASE with count 1; in RELEASE, DEBOUNCE_CNT consecutive released ticks SHALL clear key_held and return to SCAN on row0; any pressed tick SHALL return to HELD.
REQ-013 Emit with key_valid low SHALL load key_code and set key_valid on the next edge.
REQ-014 key_valid SHALL stay high and key_code stable until a clk edge samples key_ack high; key_ack while key_valid low SHALL be ignored.
REQ-015 Emit while key_valid high and key_ack low SHALL drop the new key and set overrun.
REQ-016 Emit with key_valid high and key_ack high in the same cycle SHALL load the new key_code, keep key_valid high and leave overrun unchanged.
REQ-017 overrun SHALL clear only on reset.

Reset
REQ-018 rst_n low SHALL asynchronously force: state SCAN, row 4'b1110, key_code 0, key_valid 0, key_held 0, overrun 0, tick counter 0, synchronisers 4'b1111.
REQ-019 Reset asserted mid-debounce or mid-hold SHALL discard the pending key; scanning SHALL restart at row0 on the first tick after release.

Configuration
REQ-020 With KEY_SCANNER_TYPEMATIC_EN defined, HELD SHALL re-emit the held key 32 ticks after the original emit and every 8 ticks thereafter, each subject to REQ-013..REQ-016.
REQ-021 Without KEY_SCANNER_TYPEMATIC_EN, one press SHALL produce exactly one emit; the repeat counter SHALL not exist.

Structure
REQ-022 Package key_scanner_pkg SHALL hold the FSM state type, the 16-entry KEY_MAP constant, row-pattern constants ROW_IDLE=4'b1110 and COL_NONE=4'b1111, and the typematic constants 32 and 8.
REQ-023 The tick divider SHALL be sub-module scan_tick_gen with parameter SCAN_DIV and outputs tick.

Verification
REQ-024 SCAN_DIV=4, DEBOUNCE_CNT=2, no press -> row cycles 1110,1101,1011,0111,1110 with a change every 4 clk; key_valid stays 0.
REQ-025 Press row2/col1 held 10 ticks, ack one cycle after key_valid -> key_code=4'h8, key_valid high until the ack edge, key_held high until 2 released ticks.
REQ-026 Bounce col 1110/1111 alternating each tick for 6 ticks on row0, then stable 1110 -> exactly one key_code=4'h1.
REQ-027 Press '5', no ack, then press '9' -> key_code stays 4'h5, overrun=1; a '0' emit coinciding with key_ack loads 4'h0 and keeps key_valid=1.
REQ-028 col=4'b1010 on row1 -> no key_valid; rst_n pulsed low mid-DEBOUNCE -> all outputs at reset values and row=1110 immediately.
REQ-029 With KEY_SCANNER_TYPEMATIC_EN, hold 'A' 50 ticks, ack each key -> emits at tick 0, 32, 40 and 48.
